// File: rtl/gao_er1_responder.sv
// rtl/gao_er1_responder.sv - ER1 user data register responder in the TCK domain; optional macro GAO_ER1_LEN_CHECK_EN
module gao_er1_responder #(
  parameter int DATA_W = 32
) (
  input  logic              tck_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              shift_dr_capture_dr_i,
  input  logic              update_dr_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  output logic [DATA_W-1:0] cmd_o,
  output logic              cmd_valid_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  output logic              frame_err_o
);

  localparam int DR_W = DATA_W + 4;

  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_RD_ACK = 4'h2;
  localparam logic [3:0] OP_CLR    = 4'h3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_UPD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DR_W-1:0]   sr;
  logic              ovf;
  logic              do_capture;
  logic              do_shift;
  logic              do_update;
  logic              len_ok;
  logic [3:0]        op;
  logic [DATA_W-1:0] pl;
  logic              wr_hit;
  logic              ack_hit;
  logic              clr_hit;

  assign op = sr[DR_W-1 -: 4];
  assign pl = sr[DATA_W-1:0];

  // Next-state decode; also produces the capture/shift/update strobes for the datapath
  always_comb begin
    state_nxt  = state;
    do_capture = 1'b0;
    do_shift   = 1'b0;
    do_update  = 1'b0;
    case (state)
      IDLE: begin
        // Update without a preceding capture is ignored here by construction
        if (enable_i && shift_dr_capture_dr_i) begin
          do_capture = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT, WAIT_UPD: begin
        if (!enable_i) begin
          state_nxt = IDLE;
        end else if (update_dr_i) begin
          do_update = 1'b1;
          state_nxt = IDLE;
        end else if (shift_dr_capture_dr_i) begin
          // Returning from Pause resumes shifting without a recapture
          do_shift  = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = WAIT_UPD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shift register: parallel capture of status/readback, then LSB-first shifting
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      sr <= '0;
    end else if (do_capture) begin
      sr <= {rd_valid_i, frame_err_o, ovf, 1'b1, rd_data_i};
    end else if (do_shift) begin
      sr <= {tdi_i, sr[DR_W-1:1]};
    end
  end

`ifdef GAO_ER1_LEN_CHECK_EN
  localparam int CNT_W = $clog2(DR_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_W + 1);

  logic [CNT_W-1:0] cnt;

  // Shifted-bit counter; saturates one past a full frame so long frames stay detectable
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (do_capture) begin
      cnt <= '0;
    end else if (do_shift && (cnt != CNT_SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign len_ok = (cnt == CNT_FULL);

  // Sticky length error; a fresh error beats a CLR arriving in the same update
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
    end else if (do_update && !len_ok) begin
      frame_err_o <= 1'b1;
    end else if (clr_hit) begin
      frame_err_o <= 1'b0;
    end
  end
`else
  assign len_ok      = 1'b1;
  assign frame_err_o = 1'b0;
`endif

  assign wr_hit  = do_update && len_ok && (op == OP_WRITE);
  assign ack_hit = do_update && len_ok && (op == OP_RD_ACK);
  assign clr_hit = do_update && len_ok && (op == OP_CLR);

  // Registered command/ack pulses, one cycle after the update cycle
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      cmd_o       <= '0;
      cmd_valid_o <= 1'b0;
      rd_ready_o  <= 1'b0;
    end else begin
      cmd_valid_o <= wr_hit;
      rd_ready_o  <= ack_hit && rd_valid_i;
      if (wr_hit) begin
        cmd_o <= pl;
      end
    end
  end

  // Sticky overflow: host acknowledged a readback word that was never valid
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      ovf <= 1'b0;
    end else if (ack_hit && !rd_valid_i) begin
      ovf <= 1'b1;
    end else if (clr_hit) begin
      ovf <= 1'b0;
    end
  end

  assign tdo_o = enable_i ? sr[0] : 1'b0;

endmodule

// File: tb/tb_gao_er1_responder.sv
// tb/tb_gao_er1_responder.sv - directed self-checking bench for gao_er1_responder
module tb_gao_er1_responder;

  logic        tck = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sdc = 1'b0;
  logic        upd = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic [31:0] rd_data = 32'h0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic        frame_err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [35:0] dout;
  logic        cv_cap;
  logic [35:0] w;
  logic [35:0] w35;

  gao_er1_responder #(.DATA_W(32)) dut (
    .tck_i                 (tck),
    .rst_i                 (rst),
    .enable_i              (en),
    .shift_dr_capture_dr_i (sdc),
    .update_dr_i           (upd),
    .tdi_i                 (tdi),
    .tdo_o                 (tdo),
    .cmd_o                 (cmd),
    .cmd_valid_o           (cmd_valid),
    .rd_data_i             (rd_data),
    .rd_valid_i            (rd_valid),
    .rd_ready_o            (rd_ready),
    .frame_err_o           (frame_err)
  );

  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture();
    en  = 1'b1;
    sdc = 1'b1;
    upd = 1'b0;
    tick();
    cv_cap = cmd_valid;
  endtask

  task automatic shift(input logic [35:0] din, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      tdi = din[lo+i];
      dout[lo+i] = tdo;
      tick();
    end
  endtask

  task automatic finish_frame();
    sdc = 1'b0;
    tdi = 1'b0;
    tick();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  task automatic frame(input logic [35:0] din);
    capture();
    shift(din, 0, 36);
    finish_frame();
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset_tdo", tdo, 0);
    chk("reset_cmd", cmd, 0);
    chk("reset_cmd_valid", cmd_valid, 0);
    chk("reset_rd_ready", rd_ready, 0);
    chk("reset_frame_err", frame_err, 0);

    rd_valid = 1'b1;
    rd_data  = 32'hDEADBEEF;
    frame(36'h0_00000000);
    chk("capture_readout", dout, 36'h9_DEADBEEF);
    chk("nop_cmd_valid", cmd_valid, 0);
    chk("nop_rd_ready", rd_ready, 0);

    frame({4'h1, 32'h12345678});
    chk("write_cmd_valid", cmd_valid, 1);
    chk("write_cmd", cmd, 32'h12345678);
    chk("write_rd_ready", rd_ready, 0);

    frame({4'h2, 32'h0});
    chk("write_pulse_one_cycle", cv_cap, 0);
    chk("rdack_rd_ready", rd_ready, 1);
    chk("rdack_cmd_valid", cmd_valid, 0);
    chk("rdack_cmd_hold", cmd, 32'h12345678);
    sdc = 1'b0;
    tick();
    chk("rdack_pulse_one_cycle", rd_ready, 0);

    rd_valid = 1'b0;
    rd_data  = 32'hA5A50F0F;
    frame({4'h2, 32'h0});
    chk("rdack_invalid_no_pulse", rd_ready, 0);
    frame({4'h3, 32'h0});
    chk("ovf_captured", dout, 36'h3_A5A50F0F);
    frame(36'h0_00000000);
    chk("ovf_cleared", dout, 36'h1_A5A50F0F);

    rd_valid = 1'b1;
    rd_data  = 32'hDEADBEEF;
    w   = {4'h1, 32'hCAFEF00D};
    w35 = w >> 1;
    capture();
    shift(w35, 0, 35);
    finish_frame();
`ifdef GAO_ER1_LEN_CHECK_EN
    chk("short_cmd_unchanged", cmd, 32'h12345678);
    chk("short_cmd_valid", cmd_valid, 0);
    chk("short_frame_err", frame_err, 1);
`else
    chk("short_cmd_updated", cmd, 32'hCAFEF00D);
    chk("short_cmd_valid", cmd_valid, 1);
    chk("short_frame_err", frame_err, 0);
`endif
    sdc = 1'b0;
    tick();
    frame({4'h3, 32'h0});
`ifdef GAO_ER1_LEN_CHECK_EN
    chk("err_captured", dout[35:32], 4'hD);
`else
    chk("err_captured", dout[35:32], 4'h9);
`endif
    chk("clr_frame_err", frame_err, 0);

    w = {4'h1, 32'h0BADF00D};
    capture();
    shift(w, 0, 20);
    sdc = 1'b0;
    repeat (5) tick();
    sdc = 1'b1;
    shift(w, 20, 16);
    finish_frame();
    chk("pause_cmd", cmd, 32'h0BADF00D);
    chk("pause_cmd_valid", cmd_valid, 1);
    sdc = 1'b0;
    tick();
    chk("pause_pulse_one_cycle", cmd_valid, 0);

    w = {4'h1, 32'h55AA55AA};
    capture();
    shift(w, 0, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sdc = 1'b0;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    chk("midreset_cmd_valid", cmd_valid, 0);
    chk("midreset_cmd", cmd, 0);
    chk("midreset_rd_ready", rd_ready, 0);
    chk("midreset_frame_err", frame_err, 0);
    chk("midreset_tdo", tdo, 0);
    tick();
    chk("midreset_no_late_pulse", cmd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
